// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the byte-serial imem program loader.
package imem_loader_pkg;

    localparam int BYTE_W         = 8;
    localparam int DEF_PROG_BYTES = 64;
    localparam int CHK_W          = 8;

    // Loader-level states; SETUP/STROBE/GAP live in the strobe sequencer as phases.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECV,
        ST_WRITE,
        ST_CHK,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_SETUP,
        PH_STROBE,
        PH_GAP
    } phase_t;

endpackage

// File: rtl/imem_we_pulse.sv
// SETUP -> STROBE(STROBE_CYCLES) -> GAP sequencer producing one clean imem_we
// pulse per go; done is high during the GAP cycle.
module imem_we_pulse
    import imem_loader_pkg::*;
#(
    parameter int STROBE_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic go,
    output logic imem_we,
    output logic strobe_go,
    output logic done
);

    localparam int CW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

    phase_t        phase, phase_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          we_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase   <= PH_IDLE;
            cnt     <= '0;
            imem_we <= 1'b0;
        end else begin
            phase   <= phase_d;
            cnt     <= cnt_d;
            imem_we <= we_d;
        end
    end

    always_comb begin
        phase_d = phase;
        cnt_d   = cnt;
        we_d    = 1'b0;
        case (phase)
            PH_IDLE:  if (go) phase_d = PH_SETUP;
            PH_SETUP: begin
                phase_d = PH_STROBE;
                cnt_d   = '0;
                we_d    = 1'b1;
            end
            PH_STROBE: begin
                if (cnt == CW'(STROBE_CYCLES - 1)) begin
                    phase_d = PH_GAP;
                end else begin
                    cnt_d = cnt + CW'(1);
                    we_d  = 1'b1;
                end
            end
            PH_GAP:   phase_d = PH_IDLE;
            default:  phase_d = PH_IDLE;
        endcase
    end

    // Registered phase makes these one-cycle markers: SETUP precedes the rise.
    assign strobe_go = (phase == PH_SETUP);
    assign done      = (phase == PH_GAP);

endmodule

// File: rtl/imem_loader.sv
// Byte-serial imem program loader with CPU hold. Optional trailing checksum
// byte check is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int PROG_BYTES    = DEF_PROG_BYTES,
    parameter int STROBE_CYCLES = 1,
    parameter int PTR_W         = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              boot_skip,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [BYTE_W-1:0] imem_byte,
    output logic [PTR_W-1:0]  wr_ptr,
    output logic              busy,
    output logic              load_done,
    output logic              cpu_hold,
    output logic              chk_err
);

    localparam int CNT_W = $clog2(PROG_BYTES + 1);

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt;
    logic             accept, go, strobe_go, wr_done, last;
    logic             chk_err_d;

    // in_ready is registered and only high in RECV/CHK, so it qualifies accept.
    assign accept = in_ready && in_valid;
    assign go     = accept && (state == ST_RECV);
    assign last   = (cnt == CNT_W'(PROG_BYTES));

    imem_we_pulse #(
        .STROBE_CYCLES(STROBE_CYCLES)
    ) u_pulse (
        .clk      (clk),
        .rst_n    (rst_n),
        .go       (go),
        .imem_we  (imem_we),
        .strobe_go(strobe_go),
        .done     (wr_done)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [CHK_W-1:0] sum;
    logic             chk_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum       <= '0;
            chk_err_q <= 1'b0;
        end else begin
            if (go) sum <= sum + CHK_W'(in_data);
            chk_err_q <= chk_err_d;
        end
    end

    assign chk_err = chk_err_q;
`else
    assign chk_err = 1'b0;
`endif

    always_comb begin
        state_d   = state;
        chk_err_d = chk_err;
        case (state)
            ST_IDLE: begin
                if (boot_skip)  state_d = ST_DONE;
                else if (start) state_d = ST_RECV;
            end
            ST_RECV:  if (accept) state_d = ST_WRITE;
            ST_WRITE: begin
                if (wr_done) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = last ? ST_CHK : ST_RECV;
`else
                    state_d = last ? ST_DONE : ST_RECV;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (accept) begin
                    state_d   = ST_DONE;
                    chk_err_d = (CHK_W'(sum + CHK_W'(in_data)) != '0);
                end
            end
`endif
            ST_DONE:  state_d = ST_DONE;
            default:  state_d = state;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            imem_byte <= '0;
            wr_ptr    <= '0;
            cnt       <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            load_done <= 1'b0;
            cpu_hold  <= 1'b1;
        end else begin
            state <= state_d;
            if (go) imem_byte <= in_data;
            if (strobe_go) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                cnt    <= cnt + CNT_W'(1);
            end
            in_ready  <= (state_d == ST_RECV) || (state_d == ST_CHK);
            busy      <= (state_d == ST_RECV) || (state_d == ST_WRITE) || (state_d == ST_CHK);
            load_done <= (state_d == ST_DONE);
            cpu_hold  <= !((state_d == ST_DONE) && !chk_err_d);
        end
    end

endmodule
